dmem_responder: RTL

- Memory-side responder for CPU data accesses; the counterpart to the CPU's load/store initiator port.
- Accepts one word-wide read or write request through a valid/ready handshake and services it against an internal word array after a configurable number of wait states.
- Returns the result through a second valid/ready handshake.
- Used when the data memory is moved behind a latency-bearing bus for the multi-cycle and pipelined CPU variants.

---
 rtl/dmem_responder.sv | 120 ++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - word-wide data memory responder with wait states and valid/ready handshakes
// Optional feature macro: DMEM_ACCESS_FAULT_EN (misaligned / out-of-range access faults)
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic        reqWrite,
  input  logic [31:0] reqAddress,
  input  logic [31:0] reqWriteData,
  output logic        rspValid,
  input  logic        rspReady,
  output logic [31:0] rspReadData,
  output logic        rspError,
  output logic        busy
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              write_q;
  logic [31:0]       addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic              err_q;
  logic [31:0]       mem_q [DEPTH_WORDS];
  logic [IDX_W-1:0]  idx;
  logic              fault;
  logic              accept;

  assign idx    = addr_q[IDX_W+1:2];
  assign accept = reqValid && reqReady;

`ifdef DMEM_ACCESS_FAULT_EN
  // Depth is a power of two, so any set bit above the index field is out of range.
  assign fault = (addr_q[1:0] != 2'b00) || (|addr_q[31:IDX_W+2]);
`else
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr_q[31:IDX_W+2], addr_q[1:0]};
  assign fault = 1'b0;
`endif

  // Handshake outputs decode the state and are forced low while reset is held.
  assign reqReady    = rst && (state_q == S_IDLE);
  assign rspValid    = rst && (state_q == S_RESP);
  assign busy        = rst && (state_q != S_IDLE);
  assign rspReadData = rdata_q;
  assign rspError    = err_q;

  // Next-state logic: wait-state countdown and response handshake.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          cnt_d   = 4'(WAIT_STATES);
          state_d = (WAIT_STATES > 0) ? S_WAIT : S_ACCESS;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = S_ACCESS;
      end
      S_ACCESS: state_d = S_RESP;
      S_RESP: begin
        if (rspReady) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state, request latch and response registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      write_q <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        write_q <= reqWrite;
        addr_q  <= reqAddress;
        wdata_q <= reqWriteData;
        err_q   <= 1'b0;
      end
      if (state_q == S_ACCESS) begin
        if (fault) begin
          rdata_q <= 32'd0;
          err_q   <= 1'b1;
        end else if (write_q) begin
          rdata_q <= 32'd0;
        end else begin
          rdata_q <= mem_q[idx];
        end
      end
    end
  end

  // Word array: cleared on reset, written only by a non-faulting store in ACCESS.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem_q[i] <= 32'd0;
    end else if ((state_q == S_ACCESS) && write_q && !fault) begin
      mem_q[idx] <= wdata_q;
    end
  end

endmodule
